// File: rtl/dds_wave_gen.sv
// rtl/dds_wave_gen.sv - phase-accumulator waveform generator (sine/saw/triangle/square), 3-stage pipeline
module dds_wave_gen #(
    parameter int ACC_W = 24
) (
    input  logic             Fg_CLK,
    input  logic             RESET,
    input  logic             Ready,
    input  logic             Enable,
    input  logic [ACC_W-1:0] TuningWord,
    input  logic [1:0]       WaveSel,
    output logic [7:0]       Sample,
    output logic             SampleValid
);

    logic [ACC_W-1:0] acc;
    logic             v0;
    logic [7:0]       p1;
    logic [1:0]       sel1;
    logic             v1;
    logic [7:0]       wave;
    logic             strobe;

    assign strobe = Ready && Enable;

    // Quarter-wave sine magnitude: round(127*sin((pi/2)*(i+0.5)/64))
    function automatic logic [6:0] sine_q(input logic [5:0] i);
        case (i)
            6'd0:  sine_q = 7'd2;   6'd1:  sine_q = 7'd5;   6'd2:  sine_q = 7'd8;   6'd3:  sine_q = 7'd11;
            6'd4:  sine_q = 7'd14;  6'd5:  sine_q = 7'd17;  6'd6:  sine_q = 7'd20;  6'd7:  sine_q = 7'd23;
            6'd8:  sine_q = 7'd26;  6'd9:  sine_q = 7'd29;  6'd10: sine_q = 7'd32;  6'd11: sine_q = 7'd35;
            6'd12: sine_q = 7'd38;  6'd13: sine_q = 7'd41;  6'd14: sine_q = 7'd44;  6'd15: sine_q = 7'd47;
            6'd16: sine_q = 7'd50;  6'd17: sine_q = 7'd53;  6'd18: sine_q = 7'd56;  6'd19: sine_q = 7'd58;
            6'd20: sine_q = 7'd61;  6'd21: sine_q = 7'd64;  6'd22: sine_q = 7'd67;  6'd23: sine_q = 7'd69;
            6'd24: sine_q = 7'd72;  6'd25: sine_q = 7'd74;  6'd26: sine_q = 7'd77;  6'd27: sine_q = 7'd79;
            6'd28: sine_q = 7'd82;  6'd29: sine_q = 7'd84;  6'd30: sine_q = 7'd86;  6'd31: sine_q = 7'd89;
            6'd32: sine_q = 7'd91;  6'd33: sine_q = 7'd93;  6'd34: sine_q = 7'd95;  6'd35: sine_q = 7'd97;
            6'd36: sine_q = 7'd99;  6'd37: sine_q = 7'd101; 6'd38: sine_q = 7'd103; 6'd39: sine_q = 7'd105;
            6'd40: sine_q = 7'd106; 6'd41: sine_q = 7'd108; 6'd42: sine_q = 7'd110; 6'd43: sine_q = 7'd111;
            6'd44: sine_q = 7'd113; 6'd45: sine_q = 7'd114; 6'd46: sine_q = 7'd115; 6'd47: sine_q = 7'd117;
            6'd48: sine_q = 7'd118; 6'd49: sine_q = 7'd119; 6'd50: sine_q = 7'd120; 6'd51: sine_q = 7'd121;
            6'd52: sine_q = 7'd122; 6'd53: sine_q = 7'd123; 6'd54: sine_q = 7'd124; 6'd55: sine_q = 7'd124;
            6'd56: sine_q = 7'd125; 6'd57: sine_q = 7'd125; 6'd58: sine_q = 7'd126; 6'd59: sine_q = 7'd126;
            default: sine_q = 7'd127;
        endcase
    endfunction

    // Stage 0: advance the phase accumulator on each accepted strobe
    always_ff @(posedge Fg_CLK) begin
        if (RESET) begin
            acc <= '0;
            v0  <= 1'b0;
        end else begin
            v0 <= strobe;
            if (strobe) begin
                acc <= acc + TuningWord;
            end
        end
    end

    // Stage 1: capture the top phase byte and the waveform select together
    always_ff @(posedge Fg_CLK) begin
        if (RESET) begin
            p1   <= 8'd0;
            sel1 <= 2'd0;
            v1   <= 1'b0;
        end else begin
            v1 <= v0;
            if (v0) begin
                p1   <= acc[ACC_W-1 -: 8];
                sel1 <= WaveSel;
            end
        end
    end

    // Waveform shaping from the stage-1 phase; odd quadrants mirror the LUT index
    always_comb begin
        logic [5:0] idx;
        logic [6:0] mag;
        logic [7:0] dbl;
        wave = 8'd128;
        idx  = p1[6] ? ~p1[5:0] : p1[5:0];
        mag  = sine_q(idx);
        dbl  = {p1[6:0], 1'b0};
        case (sel1)
            2'd0:    wave = p1[7] ? (8'd128 - {1'b0, mag}) : (8'd128 + {1'b0, mag});
            2'd1:    wave = p1;
            2'd2:    wave = p1[7] ? ~dbl : dbl;
            default: wave = p1[7] ? 8'd0 : 8'd255;
        endcase
    end

    // Stage 2: register the sample; it holds between valid pulses
    always_ff @(posedge Fg_CLK) begin
        if (RESET) begin
            Sample      <= 8'd128;
            SampleValid <= 1'b0;
        end else begin
            SampleValid <= v1;
            if (v1) begin
                Sample <= wave;
            end
        end
    end

endmodule

// File: tb/tb_dds_wave_gen.sv
// tb/tb_dds_wave_gen.sv - randomized and directed self-checking bench for dds_wave_gen
module tb_dds_wave_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        en  = 1'b0;
    logic [23:0] tw  = 24'd0;
    logic [1:0]  ws  = 2'd0;
    logic [7:0]  smp;
    logic        sv;

    int errors = 0;
    int checks = 0;

    dds_wave_gen #(.ACC_W(24)) dut (
        .Fg_CLK(clk), .RESET(rst), .Ready(rdy), .Enable(en),
        .TuningWord(tw), .WaveSel(ws), .Sample(smp), .SampleValid(sv)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  got_q[$];
    int          cyc = 0;
    bit          started = 0;
    logic [23:0] acc_m = 24'd0;
    bit          have_pend = 0;
    logic [7:0]  pend_p = 8'd0;
    bit          exp_valid = 0;
    logic [7:0]  exp_sample = 8'd128;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Waveform value straight from the waveform definitions
    function automatic logic [7:0] ref_wave(input logic [7:0] p, input logic [1:0] s);
        real x;
        int  pi_;
        pi_ = int'(p);
        case (s)
            2'd0: begin
                x = 127.0 * $sin(2.0 * 3.14159265358979 * (real'(pi_) + 0.5) / 256.0);
                if (x >= 0.0) ref_wave = 8'(128 + $rtoi(x + 0.5));
                else          ref_wave = 8'(128 - $rtoi(-x + 0.5));
            end
            2'd1: ref_wave = p;
            2'd2: ref_wave = (pi_ < 128) ? 8'(2 * pi_) : 8'(255 - 2 * (pi_ - 128));
            default: ref_wave = (pi_ < 128) ? 8'd255 : 8'd0;
        endcase
    endfunction

    // Reference model: evaluate the inputs seen at each rising edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            started    = 1;
            acc_m      = 24'd0;
            have_pend  = 0;
            exp_q.delete();
            exp_valid  = 0;
            exp_sample = 8'd128;
        end else begin
            exp_valid = 0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                exp_valid  = 1;
                exp_sample = exp_q[0].val;
                void'(exp_q.pop_front());
            end
            if (have_pend) begin
                exp_q.push_back('{due: cyc + 1, val: ref_wave(pend_p, ws)});
                have_pend = 0;
            end
            if (rdy && en) begin
                acc_m     = acc_m + tw;
                pend_p    = acc_m[23:16];
                have_pend = 1;
            end
        end
    end

    // Compare process: outputs against the model every cycle after the first reset
    always @(negedge clk) begin
        if (started) begin
            chk("sample_valid", int'(sv), int'(exp_valid));
            chk("sample", int'(smp), int'(exp_sample));
            if (sv) got_q.push_back(smp);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rdy = 1'($urandom); en = 1'($urandom);
            tw = 24'($urandom); ws = 2'($urandom);
            @(negedge clk);
        end
        rst = 1'b0; en = 1'b0; rdy = 1'b1;
    endtask

    task automatic strobe();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    initial begin
        logic [7:0]  sine_exp[4];
        logic [23:0] tw2;
        int          n;
        sine_exp[0] = 8'd255; sine_exp[1] = 8'd126; sine_exp[2] = 8'd1; sine_exp[3] = 8'd130;

        @(negedge clk);
        do_reset();
        chk("reset_sample", int'(smp), 128);
        chk("reset_valid", int'(sv), 0);

        // Strobes while not ready are ignored
        got_q.delete();
        rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            en = 1'($urandom); tw = 24'($urandom);
            @(negedge clk);
        end
        en = 1'b0; tick(3);
        chk("not_ready_valids", got_q.size(), 0);

        // Sawtooth sweep across the wrap
        do_reset(); got_q.delete();
        ws = 2'd1; tw = 24'h010000;
        for (int i = 0; i < 257; i++) begin
            strobe(); tick(1);
        end
        tick(3);
        chk("saw_count", got_q.size(), 257);
        if (got_q.size() == 257) begin
            chk("saw_first", int'(got_q[0]), 1);
            chk("saw_254", int'(got_q[254]), 255);
            chk("saw_wrap", int'(got_q[255]), 0);
            chk("saw_last", int'(got_q[256]), 1);
        end

        // Sine at quadrant boundaries
        do_reset(); got_q.delete();
        ws = 2'd0; tw = 24'h400000;
        for (int i = 0; i < 8; i++) begin
            strobe(); tick($urandom_range(0, 3));
        end
        tick(3);
        chk("sine_count", got_q.size(), 8);
        n = got_q.size();
        for (int i = 0; i < n && i < 8; i++) chk("sine_val", int'(got_q[i]), int'(sine_exp[i % 4]));

        // Triangle then square with half-turn steps
        do_reset(); got_q.delete();
        tw = 24'h800000; ws = 2'd2;
        strobe(); tick(1); strobe(); tick(2);
        ws = 2'd3;
        strobe(); tick(1); strobe(); tick(3);
        chk("tri_sq_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            chk("tri_128", int'(got_q[0]), 255);
            chk("tri_0", int'(got_q[1]), 0);
            chk("sq_128", int'(got_q[2]), 0);
            chk("sq_0", int'(got_q[3]), 255);
        end

        // Back-to-back strobes every cycle
        do_reset(); got_q.delete();
        ws = 2'd1; tw = 24'h010000;
        en = 1'b1; tick(10); en = 1'b0;
        tick(3);
        chk("b2b_count", got_q.size(), 10);
        n = got_q.size();
        for (int i = 0; i < n && i < 10; i++) chk("b2b_val", int'(got_q[i]), i + 1);

        // Reset while a sample is in flight
        do_reset(); got_q.delete();
        ws = 2'd1; tw = 24'($urandom);
        en = 1'b1; @(negedge clk);
        en = 1'b0; rst = 1'b1; @(negedge clk);
        rst = 1'b0; tick(4);
        chk("flush_valids", got_q.size(), 0);
        tw2 = 24'($urandom); tw = tw2;
        strobe(); tick(3);
        chk("post_flush_count", got_q.size(), 1);
        if (got_q.size() == 1) chk("post_flush_val", int'(got_q[0]), int'(tw2[23:16]));

        // Zero tuning word still produces samples
        do_reset(); got_q.delete();
        ws = 2'd0; tw = 24'd0;
        strobe(); strobe(); tick(3);
        chk("tw0_count", got_q.size(), 2);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            en  = 1'($urandom);
            if ($urandom_range(0, 7) == 0) tw = 24'($urandom);
            if ($urandom_range(0, 5) == 0) ws = 2'($urandom);
            @(negedge clk);
        end
        rst = 1'b0; en = 1'b0;
        tick(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
